// File: rtl/main_mem_arb_pkg.sv
// main_mem_arb_pkg: shared state type, port ids and default widths for the main-memory arbiter
package main_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, ACK} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int ADDR_W_DEF = 28;
  localparam int BLOCK_W_DEF = 128;
endpackage

// File: rtl/main_mem_arb_picker.sv
// main_mem_arb_picker: combinational winner select; ties alternate when ARB_ROUND_ROBIN_EN is defined
module main_mem_arb_picker
  import main_mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant
);
  // Ties go opposite to the previous grant; otherwise the lone requester wins
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant = (i_req && d_req) ? ~last_grant : (d_req ? PORT_D : PORT_I);
`else
    grant = (d_req || !i_req) ? PORT_D : PORT_I;
`endif
  end
endmodule

// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: serialises icache/dcache block requests onto one memory port (ARB_ROUND_ROBIN_EN: round-robin ties)
module main_mem_arbiter
  import main_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_READ_DATA,
  output logic               I_BUSY_WAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_WRITE_DATA,
  output logic [BLOCK_W-1:0] D_READ_DATA,
  output logic               D_BUSY_WAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITE_DATA,
  input  logic [BLOCK_W-1:0] MEM_READ_DATA,
  input  logic               MEM_BUSY_WAIT
);
  state_t state, state_nx;
  logic issued, ack_i, ack_d, grant, d_req, req, done, serving;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
`endif
  assign d_req = D_READ || D_WRITE;
  assign req = I_READ || d_req;
  assign done = issued && !MEM_BUSY_WAIT;
  assign serving = (state == SERVE_I) || (state == SERVE_D);
  assign I_BUSY_WAIT = I_READ && !ack_i;
  assign D_BUSY_WAIT = d_req && !ack_d;
  main_mem_arb_picker u_picker (
    .i_req(I_READ),
    .d_req(d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant(last_grant),
`endif
    .grant(grant)
  );
  // Next state: grant from IDLE, leave SERVE on completion, one ACK cycle guards against re-grant
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = req ? ((grant == PORT_D) ? SERVE_D : SERVE_I) : IDLE;
      SERVE_I, SERVE_D: state_nx = done ? ACK : state;
      default: state_nx = IDLE;
    endcase
  end
  // Registered strobes, latched address/data, read-data capture and one-cycle acks
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      issued <= 1'b0;
      ack_i <= 1'b0;
      ack_d <= 1'b0;
      MEM_READ <= 1'b0;
      MEM_WRITE <= 1'b0;
      MEM_ADDRESS <= '0;
      MEM_WRITE_DATA <= '0;
      I_READ_DATA <= '0;
      D_READ_DATA <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= PORT_I;
`endif
    end else begin
      state <= state_nx;
      ack_i <= 1'b0;
      ack_d <= 1'b0;
      if (state == IDLE && req) begin
        issued <= 1'b1;
        MEM_ADDRESS <= (grant == PORT_D) ? D_ADDRESS : I_ADDRESS;
        MEM_WRITE_DATA <= (grant == PORT_D) ? D_WRITE_DATA : MEM_WRITE_DATA;
        MEM_READ <= (grant == PORT_I) || !D_WRITE;
        MEM_WRITE <= (grant == PORT_D) && D_WRITE;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant <= grant;
`endif
      end
      if (serving && done) begin
        issued <= 1'b0;
        MEM_READ <= 1'b0;
        MEM_WRITE <= 1'b0;
        ack_i <= state == SERVE_I;
        ack_d <= state == SERVE_D;
        I_READ_DATA <= (state == SERVE_I) ? MEM_READ_DATA : I_READ_DATA;
        D_READ_DATA <= (state == SERVE_D && MEM_READ) ? MEM_READ_DATA : D_READ_DATA;
      end
    end
  end
  // Flag a dcache request that asks for both read and write; it is served as a write
  always @(posedge CLK) begin
    if (!RESET && state == IDLE)
      assert (!(D_READ && D_WRITE)) else $warning("dcache read and write both high, serving as write");
  end
endmodule

// File: doc/main_mem_arbiter.md
Name: main_mem_arbiter

Overview:
- Sits directly downstream of the CPU's instruction cache and data cache.
- Multiplexes their block-level main-memory requests onto a single shared main-memory port.
- Each cache keeps its existing busy-wait handshake and sees the arbiter as a private memory.
- Serialises transactions, latches address and write data at grant, and returns the read block with a one-cycle completion window.

Parameters:
- ADDR_W, 28, block address width (byte address bits above the 16-byte block offset).
- BLOCK_W, 128, cache block width in bits (4 words).

Ports:
- CLK  in  1  single system clock, all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- I_READ  in  1  icache block-read request, held until I_BUSY_WAIT is low.
- I_ADDRESS  in  ADDR_W  icache block address.
- I_READ_DATA  out  BLOCK_W  block returned to icache.
- I_BUSY_WAIT  out  1  icache stall.
- D_READ  in  1  dcache block-read request (refill).
- D_WRITE  in  1  dcache block-write request (write-back).
- D_ADDRESS  in  ADDR_W  dcache block address.
- D_WRITE_DATA  in  BLOCK_W  dcache write-back block.
- D_READ_DATA  out  BLOCK_W  block returned to dcache.
- D_BUSY_WAIT  out  1  dcache stall.
- MEM_READ  out  1  main-memory read strobe.
- MEM_WRITE  out  1  main-memory write strobe.
- MEM_ADDRESS  out  ADDR_W  main-memory block address.
- MEM_WRITE_DATA  out  BLOCK_W  main-memory write block.
- MEM_READ_DATA  in  BLOCK_W  main-memory read block.
- MEM_BUSY_WAIT  in  1  main memory busy.

Behaviour:
- Clock and reset: one clock (CLK); RESET is synchronous and active-high.
- Reset values:
  - state=IDLE, issued=0, last_grant=ICACHE.
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITE_DATA=0.
  - I_READ_DATA=D_READ_DATA=0, ack_i=ack_d=0.
- States:
  - IDLE: no transfer. No request: stay. Request present: pick a winner, latch its address (and write data for D) into the MEM_* output registers, drive MEM_READ or MEM_WRITE from the next edge, go to SERVE_I or SERVE_D.
  - SERVE_I / SERVE_D: strobe held. issued is set on the first SERVE cycle.
    - Completion = issued && !MEM_BUSY_WAIT.
    - On completion: register MEM_READ_DATA into the port's read-data register (reads only), clear strobes and issued, pulse ack_x for one cycle, go to ACK.
  - ACK: one cycle, then IDLE. This prevents re-granting a requester whose request is still high during its ack cycle.
- Busy-wait outputs:
  - I_BUSY_WAIT = I_READ && !ack_i.
  - D_BUSY_WAIT = (D_READ||D_WRITE) && !ack_d.
  - Both are combinational. A requester that is not requesting sees 0.
- Read-data outputs: valid in the ack cycle and held until that port's next completion.
- Latency: request seen in IDLE at cycle 0 → strobe high from cycle 1. With memory busy for N cycles, completion lands at cycle 1+N, ack at cycle 2+N. Minimum total is 3 cycles.
- Simultaneous I and D requests: default grant goes to D, because the MEM stage is older than IF.
- D_READ && D_WRITE both high: treated as a write. The read is ignored for that transaction. Simulation-only assertion flags it.
- Request dropped mid-SERVE: the transaction still completes. ack is produced but is invisible because busy-wait is gated by the request.
- Inputs changing mid-SERVE: address and write data are latched at grant, so changes have no effect.
- RESET mid-transaction: returns to reset values next edge and abandons the transfer. Main memory shares RESET.
- No back-to-back grant without an intervening ACK+IDLE. Throughput is one transaction per N+3 cycles.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous I/D request in IDLE, grant the port opposite to last_grant. last_grant updates at every grant and resets to ICACHE, so the first tie goes to D.
- Undefined: fixed priority, D always wins ties. last_grant is not instantiated.
- Single-requester behaviour is identical in both builds.

Decomposition:
- Package main_mem_arb_pkg:
  - state enum {IDLE, SERVE_I, SERVE_D, ACK}.
  - port-id constants PORT_I=0, PORT_D=1.
  - default ADDR_W/BLOCK_W constants.
- One sub-module, main_mem_arb_picker: combinational winner select from {I_req, D_req, last_grant}, with the round-robin logic under the macro. All sequential state stays in the top.

Test Plan:
- Icache only, I_READ=1, I_ADDRESS=0x0000010, memory busy 5 cycles returning 0xDEADBEEF_...0001 → MEM_READ high cycles 1–6, I_BUSY_WAIT low exactly at cycle 7 with I_READ_DATA=0x...0001; D_BUSY_WAIT stays 0.
- Dcache write-back, D_WRITE=1, D_ADDRESS=0x0000020, data 0x1111...; D_WRITE_DATA changed to 0x2222... in cycle 2 → memory sees address 0x20 and 0x1111... throughout; MEM_READ never asserts; ack at N+2.
- Both request in the same cycle (I addr 0x4, D addr 0x8) → D served first, I strobe begins after D's ACK+IDLE. With ARB_ROUND_ROBIN_EN, a second simultaneous tie goes to I.
- Memory zero-latency (MEM_BUSY_WAIT never high) → completion on the first SERVE cycle, ack at cycle 2, no double transaction.
- RESET asserted for one cycle during SERVE_D → next cycle all MEM_* outputs are 0, state IDLE, a pending I_READ is granted afterwards.
- D_READ and D_WRITE both high → a single MEM_WRITE transaction and the assertion fires.
